// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between an execute-stage
// requester (A) and an auxiliary requester (B). Results are captured into a
// single-entry response buffer and returned over a valid/ready handshake.
// The condition codes follow port-A arithmetic only.
module alu_share_arbiter #(
    parameter int WIDTH        = 16,
    parameter bit FIXED_PRIO_A = 1'b0
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             a_req_valid,
    output logic             a_req_ready,
    input  logic [WIDTH-1:0] a_in1,
    input  logic [WIDTH-1:0] a_in2,
    input  logic [2:0]       a_op,
    output logic             a_resp_valid,
    input  logic             a_resp_ready,

    input  logic             b_req_valid,
    output logic             b_req_ready,
    input  logic [WIDTH-1:0] b_in1,
    input  logic [WIDTH-1:0] b_in2,
    input  logic [2:0]       b_op,
    output logic             b_resp_valid,
    input  logic             b_resp_ready,

    output logic [WIDTH-1:0] resp_data,

    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,

    output logic [2:0]       ccr
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state, state_nxt;
    logic   owner;        // 0 = A holds the buffer, 1 = B
    logic   ptr;          // round-robin pointer: 0 = A next, 1 = B next
    logic   owner_ready;
    logic   can_accept;
    logic   both;
    logic   grant_a;
    logic   grant_b;
    logic   grant;
    logic   op_legal;     // granted op is one of add/not/pass1/pass2

    // Arbitration: a slot exists when the buffer is empty or drains this cycle
    always_comb begin
        owner_ready = owner ? b_resp_ready : a_resp_ready;
        can_accept  = (state == EMPTY) || owner_ready;
        both        = a_req_valid && b_req_valid;
        grant_a     = can_accept && a_req_valid &&
                      (!b_req_valid || FIXED_PRIO_A || !ptr);
        grant_b     = can_accept && b_req_valid && !grant_a;
        grant       = grant_a || grant_b;
        a_req_ready = grant_a;
        b_req_ready = grant_b;
    end

    // ALU drive: illegal opcodes go to the ALU as nop so it never sees them
    always_comb begin
        alu_in1  = '0;
        alu_in2  = '0;
        alu_ctrl = OP_NOP;
        op_legal = 1'b0;
        if (grant_a) begin
            alu_in1  = a_in1;
            alu_in2  = a_in2;
            op_legal = (a_op >= 3'b001) && (a_op <= 3'b100);
            alu_ctrl = op_legal ? a_op : OP_NOP;
        end else if (grant_b) begin
            alu_in1  = b_in1;
            alu_in2  = b_in2;
            op_legal = (b_op >= 3'b001) && (b_op <= 3'b100);
            alu_ctrl = op_legal ? b_op : OP_NOP;
        end
    end

    // Buffer occupancy state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Next-state: a grant always (re)fills; a drain without grant empties
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: state_nxt = grant ? FULL : EMPTY;
            FULL:  state_nxt = (owner_ready && !grant) ? EMPTY : FULL;
            default: state_nxt = EMPTY;
        endcase
    end

    // Response valid goes only to the port that owns the buffered result
    always_comb begin
        a_resp_valid = (state == FULL) && !owner;
        b_resp_valid = (state == FULL) &&  owner;
    end

    // Capture result and owner at the grant edge; nop/illegal return zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= 1'b0;
            resp_data <= '0;
        end else if (grant) begin
            owner     <= grant_b;
            resp_data <= op_legal ? alu_out : '0;
        end
    end

    // Pointer flips only on contended grants
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               ptr <= 1'b0;
        else if (both && grant) ptr <= ~ptr;
    end

    // CCR {neg, carry, zero}: port-A legal ops only; carry from add only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ccr <= 3'b000;
        end else if (grant_a && op_legal) begin
            ccr[2] <= alu_out[WIDTH-1];
            ccr[0] <= (alu_out == '0);
            if (alu_ctrl == OP_ADD) ccr[1] <= alu_carry;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: round-robin instance under full
// check, fixed-priority instance sharing the stimulus for the priority test.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req_valid, b_req_valid, a_resp_ready, b_resp_ready;
    logic [15:0] a_in1, a_in2, b_in1, b_in2;
    logic [2:0]  a_op, b_op;

    // round-robin instance
    logic        a_req_ready, b_req_ready, a_resp_valid, b_resp_valid;
    logic [15:0] resp_data, alu_in1, alu_in2, alu_out;
    logic [2:0]  alu_ctrl, ccr;
    logic        alu_carry;

    // fixed-priority instance
    logic        p_a_req_ready, p_b_req_ready, p_a_resp_valid, p_b_resp_valid;
    logic [15:0] p_resp_data, p_alu_in1, p_alu_in2, p_alu_out;
    logic [2:0]  p_alu_ctrl, p_ccr;
    logic        p_alu_carry;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [16:0] alu_f(input logic [2:0] c, input logic [15:0] x, input logic [15:0] y);
        case (c)
            3'b001:  return {1'b0, x} + {1'b0, y};
            3'b010:  return {1'b0, ~y};
            3'b011:  return {1'b0, x};
            3'b100:  return {1'b0, y};
            default: return 17'h0;
        endcase
    endfunction

    always_comb {alu_carry, alu_out}     = alu_f(alu_ctrl, alu_in1, alu_in2);
    always_comb {p_alu_carry, p_alu_out} = alu_f(p_alu_ctrl, p_alu_in1, p_alu_in2);

    alu_share_arbiter #(.WIDTH(16), .FIXED_PRIO_A(1'b0)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_in1(a_in1), .a_in2(a_in2),
        .a_op(a_op), .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_in1(b_in1), .b_in2(b_in2),
        .b_op(b_op), .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready),
        .resp_data(resp_data), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_carry(alu_carry), .ccr(ccr)
    );

    alu_share_arbiter #(.WIDTH(16), .FIXED_PRIO_A(1'b1)) dut_prio (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(p_a_req_ready), .a_in1(a_in1), .a_in2(a_in2),
        .a_op(a_op), .a_resp_valid(p_a_resp_valid), .a_resp_ready(a_resp_ready),
        .b_req_valid(b_req_valid), .b_req_ready(p_b_req_ready), .b_in1(b_in1), .b_in2(b_in2),
        .b_op(b_op), .b_resp_valid(p_b_resp_valid), .b_resp_ready(b_resp_ready),
        .resp_data(p_resp_data), .alu_in1(p_alu_in1), .alu_in2(p_alu_in2), .alu_ctrl(p_alu_ctrl),
        .alu_out(p_alu_out), .alu_carry(p_alu_carry), .ccr(p_ccr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_req_valid = 0; b_req_valid = 0; a_resp_ready = 0; b_resp_ready = 0;
        a_in1 = 0; a_in2 = 0; b_in1 = 0; b_in2 = 0; a_op = 0; b_op = 0;
        #1;
        chk("rst_a_resp_valid", a_resp_valid, 0);
        chk("rst_ccr", ccr, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        tick(); tick();
        rst = 1'b0;

        // Reset mid-operation: A add 7FFF+1 granted, then reset before drain
        a_req_valid = 1; a_op = 3'b001; a_in1 = 16'h7FFF; a_in2 = 16'h0001;
        #1;
        chk("mid_a_req_ready", a_req_ready, 1);
        chk("mid_alu_ctrl", alu_ctrl, 3'b001);
        chk("mid_alu_in1", alu_in1, 16'h7FFF);
        tick();
        a_req_valid = 0;
        chk("mid_a_resp_valid", a_resp_valid, 1);
        chk("mid_resp_data", resp_data, 16'h8000);
        chk("mid_ccr", ccr, 3'b100);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_resp_valid", a_resp_valid, 0);
        chk("async_rst_ccr", ccr, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_a_resp_valid", a_resp_valid, 0);
        chk("post_rst_b_resp_valid", b_resp_valid, 0);

        // Single A add FFFF+1 -> 0000, carry and zero set
        a_resp_ready = 1;
        a_req_valid = 1; a_op = 3'b001; a_in1 = 16'hFFFF; a_in2 = 16'h0001;
        #1;
        chk("add_a_req_ready", a_req_ready, 1);
        tick();
        a_req_valid = 0;
        chk("add_a_resp_valid", a_resp_valid, 1);
        chk("add_resp_data", resp_data, 16'h0000);
        chk("add_ccr", ccr, 3'b011);
        tick();
        chk("add_drained", a_resp_valid, 0);

        // A add 8000+0 then back-to-back A not 00FF (drain+refill same cycle)
        a_req_valid = 1; a_op = 3'b001; a_in1 = 16'h8000; a_in2 = 16'h0000;
        tick();
        chk("add2_resp_data", resp_data, 16'h8000);
        chk("add2_ccr", ccr, 3'b100);
        a_op = 3'b010; a_in1 = 16'h1111; a_in2 = 16'h00FF;
        #1;
        chk("not_refill_ready", a_req_ready, 1);
        tick();
        a_req_valid = 0;
        chk("not_resp_data", resp_data, 16'hFF00);
        chk("not_ccr", ccr, 3'b100);
        tick();

        // Contention: RR grants A,B,A,B; fixed-priority grants A every cycle
        b_resp_ready = 1;
        a_req_valid = 1; a_op = 3'b011; a_in1 = 16'h0000;
        b_req_valid = 1; b_op = 3'b100; b_in2 = 16'h8000;
        #1;
        chk("rr1_a_ready", a_req_ready, 1);
        chk("rr1_b_ready", b_req_ready, 0);
        chk("fp1_a_ready", p_a_req_ready, 1);
        chk("fp1_b_ready", p_b_req_ready, 0);
        tick();
        chk("rr1_a_resp", a_resp_valid, 1);
        chk("rr1_data", resp_data, 16'h0000);
        chk("rr1_ccr", ccr, 3'b001);
        chk("rr2_a_ready", a_req_ready, 0);
        chk("rr2_b_ready", b_req_ready, 1);
        chk("fp2_a_ready", p_a_req_ready, 1);
        chk("fp2_b_ready", p_b_req_ready, 0);
        tick();
        chk("rr2_b_resp", b_resp_valid, 1);
        chk("rr2_a_resp", a_resp_valid, 0);
        chk("rr2_data", resp_data, 16'h8000);
        chk("rr2_ccr", ccr, 3'b001);
        a_in1 = 16'hC000;
        #1;
        chk("rr3_a_ready", a_req_ready, 1);
        chk("fp3_b_ready", p_b_req_ready, 0);
        tick();
        chk("rr3_a_resp", a_resp_valid, 1);
        chk("rr3_data", resp_data, 16'hC000);
        chk("rr3_ccr", ccr, 3'b100);
        chk("rr4_b_ready", b_req_ready, 1);
        chk("fp4_a_ready", p_a_req_ready, 1);
        chk("fp4_b_ready", p_b_req_ready, 0);
        tick();
        chk("rr4_b_resp", b_resp_valid, 1);
        chk("rr4_data", resp_data, 16'h8000);
        chk("rr4_ccr", ccr, 3'b100);
        a_req_valid = 0; b_req_valid = 0;
        tick();

        // Backpressure: B pass-in1 1234 held while A waits
        b_resp_ready = 0;
        b_req_valid = 1; b_op = 3'b011; b_in1 = 16'h1234;
        #1;
        chk("bp_b_ready", b_req_ready, 1);
        tick();
        b_req_valid = 0; b_in1 = 16'hDEAD;
        a_req_valid = 1; a_op = 3'b100; a_in2 = 16'h0042;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_a_stalled", a_req_ready, 0);
            chk("bp_data_held", resp_data, 16'h1234);
            chk("bp_b_resp_valid", b_resp_valid, 1);
            tick();
        end
        b_resp_ready = 1;
        #1;
        chk("bp_a_granted", a_req_ready, 1);
        tick();
        a_req_valid = 0;
        chk("bp_a_resp", a_resp_valid, 1);
        chk("bp_b_resp_gone", b_resp_valid, 0);
        chk("bp_a_data", resp_data, 16'h0042);
        chk("bp_ccr", ccr, 3'b000);
        tick();

        // Port-B ops never touch CCR; illegal op returns zero
        b_req_valid = 1; b_op = 3'b001; b_in1 = 16'hFFFF; b_in2 = 16'h0001;
        tick();
        chk("b_wrap_data", resp_data, 16'h0000);
        chk("b_wrap_ccr", ccr, 3'b000);
        b_in1 = 16'h0001; b_in2 = 16'h0001;
        tick();
        chk("b_add_data", resp_data, 16'h0002);
        chk("b_add_valid", b_resp_valid, 1);
        chk("b_add_ccr", ccr, 3'b000);
        b_op = 3'b111; b_in1 = 16'h5555; b_in2 = 16'hAAAA;
        tick();
        b_req_valid = 0;
        chk("b_illegal_data", resp_data, 16'h0000);
        chk("b_illegal_valid", b_resp_valid, 1);
        chk("b_illegal_ccr", ccr, 3'b000);
        tick();
        chk("b_final_drain", b_resp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational 16-bit ALU between two requesters: port A (execute stage) and port B (auxiliary unit, e.g. address or stack-pointer update).
- Arbitrates, drives the ALU operand and control inputs, and registers the result into a one-entry response buffer.
- Returns each result to its requester over a valid/ready handshake.
- Maintains the condition-code register (CCR) from port-A operations only.

Parameters:
- WIDTH, 16, operand/result width
- FIXED_PRIO_A, 0, 0 = round-robin between A and B; 1 = A always wins

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- a_req_valid  in  1  port A request valid
- a_req_ready  out  1  port A request accepted this cycle
- a_in1, a_in2  in  WIDTH  port A operands
- a_op  in  3  port A ALU op: 000 nop, 001 add, 010 not in2, 011 pass in1, 100 pass in2
- a_resp_valid  out  1  port A result valid
- a_resp_ready  in  1  port A consumes result
- b_req_valid, b_req_ready, b_in1, b_in2, b_op, b_resp_valid, b_resp_ready: same meanings for port B
- resp_data  out  WIDTH  registered result, shared by both ports
- alu_in1, alu_in2  out  WIDTH  to ALU
- alu_ctrl  out  3  to ALU
- alu_out  in  WIDTH  from ALU
- alu_carry  in  1  ALU carry (flag[1]); valid for add only
- ccr  out  3  {neg, carry, zero}

Behaviour:
- Reset (async, any time): all outputs and state go to 0; grant pointer = A; response buffer empty.
  - A request in flight or a result held at reset is discarded; no response is produced after reset.
- Response buffer: buf_full, buf_owner (A/B), resp_data.
  - x_resp_valid = buf_full && buf_owner==x.
- can_accept = !buf_full || (owner's resp_ready this cycle).
  - Draining and refilling in the same cycle is allowed, giving one op per cycle throughput.
- Grant (combinational; at most one ready per cycle): only when can_accept.
  - Only one requester valid: grant it.
  - Both valid, FIXED_PRIO_A=1: grant A.
  - Both valid, FIXED_PRIO_A=0: grant the port indicated by the pointer. The pointer flips to the other port after each grant made while both were valid.
  - Single-requester grants leave the pointer unchanged.
- ALU drive:
  - Granted request: alu_in1/alu_in2/alu_ctrl = its operands and op.
  - No grant: alu_ctrl = 000, alu_in1 = alu_in2 = 0.
- Latency: grant in cycle N -> resp_valid asserted from cycle N+1, held with resp_data stable until resp_ready.
- Nop (op 000): accepted and completed normally with resp_data = 0; CCR unchanged.
- Illegal op (101-111): treated as nop.
- CCR: updated at the grant edge only for port-A ops 001-100.
  - zero = (alu_out==0)
  - neg = alu_out[WIDTH-1]
  - carry = alu_carry for add; carry unchanged for 010/011/100
  - Port-B ops never modify CCR.
- Requester inputs are sampled only in the grant cycle; later changes do not affect the held result.
- Response-side stall: a requester may hold x_req_valid while its own response is pending. It is not granted until that response drains, except by the same-cycle drain rule above.
- FSM, two states:
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on resp_ready with no new grant.
  - FULL -> FULL on resp_ready with a grant, or with no resp_ready.

Test Plan:
- Reset mid-operation: A add 0x7FFF+0x0001 granted, rst pulsed before a_resp_ready -> a_resp_valid=0, ccr=000 immediately (asynchronous), no response after release.
- Single A add 0xFFFF+0x0001, a_resp_ready=1 -> a_req_ready same cycle; next cycle a_resp_valid=1, resp_data=0x0000, ccr={0,1,1}.
- A add 0x8000+0x0000 (carry=0) then A not in2=0x00FF -> resp 0x8000, ccr={1,0,0}; then resp 0xFF00, ccr={1,0,0} (carry kept from the add).
- Both valid for 4 cycles, FIXED_PRIO_A=0, resp_ready=1 -> grants A,B,A,B; one response per cycle; CCR changes only on A grants. With FIXED_PRIO_A=1 -> grants A,A,A,A and B is stalled.
- Backpressure: B pass-in1 0x1234 with b_resp_ready=0 for 3 cycles, A valid meanwhile -> resp_data held at 0x1234, a_req_ready=0 for those cycles; A is granted in the cycle b_resp_ready=1 and its response appears the next cycle.
- B op 001 0x0001+0x0001 and B op 111 -> resp 0x0002 then 0x0000; ccr unchanged across both.
